// File: rtl/phy_pkt_pkg.sv
// Shared types and constants for the packet framer: output FSM states,
// footer field layout and the footer builder.
package phy_pkt_pkg;

   localparam int SEQ_W       = 16;
   localparam int LEN_W       = 15;
   localparam int FTR_W       = 32;
   localparam int FTR_LEN_LSB = 0;
   localparam int FTR_OVF_BIT = 15;
   localparam int FTR_SEQ_LSB = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_FOOTER  = 2'd3
   } frm_state_t;

   function automatic logic [FTR_W-1:0] make_footer(
      input logic [SEQ_W-1:0] seq,
      input logic             ovf,
      input logic [LEN_W-1:0] len
   );
      logic [FTR_W-1:0] f;
      f                         = '0;
      f[FTR_SEQ_LSB +: SEQ_W]   = seq;
      f[FTR_OVF_BIT]            = ovf;
      f[FTR_LEN_LSB +: LEN_W]   = len;
      return f;
   endfunction

endpackage

// File: rtl/pkt_framer_bp_if.sv
// Valid/ready word stream with an end-of-packet marker; the master drives
// data/valid/last, the slave drives ready.
interface pkt_framer_bp_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              last;
   logic              ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/pkt_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: registered RAM read that prefetches
// the next head entry, with a bypass when the head is written in the same cycle.
module pkt_sync_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 512
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] dout_reg;
   logic [AW:0]      wr_ptr_reg, wr_ptr_next;
   logic [AW:0]      rd_ptr_reg, rd_ptr_next;
   logic             do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the addresses match.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   assign do_pop      = pop && !empty;
   assign do_push     = push && (!full || do_pop);
   assign wr_ptr_next = wr_ptr_reg + (AW+1)'(do_push);
   assign rd_ptr_next = rd_ptr_reg + (AW+1)'(do_pop);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage and prefetch register are deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
      if (do_push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])) begin
         dout_reg <= din;
      end else begin
         dout_reg <= mem[rd_ptr_next[AW-1:0]];
      end
   end

   assign dout = dout_reg;

endmodule

// File: rtl/pkt_framer_bp.sv
// Packet framer: buffers payload words, wraps each packet in header/footer,
// truncates packets longer than MAX_LEN and drops their remainder.
module pkt_framer_bp
   import phy_pkt_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 512,
   parameter int                MAX_LEN  = 381,
   parameter logic [DATA_W-1:0] HDR_WORD = '1
) (
   input  logic             clock,
   input  logic             resetn,
   pkt_framer_bp_if.slave   in_bus,
   pkt_framer_bp_if.master  out_bus,
   output logic             ovf_pulse,
   output logic [SEQ_W-1:0] seq_num
);
   localparam int ENT_W = DATA_W + 2;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ENT_W-1:0] fifo_din, fifo_dout;

   // ---------------- input side ----------------
   logic             ready_en_reg, drop_reg, ovf_pulse_reg;
   logic [LEN_W-1:0] in_cnt_reg;
   logic [LEN_W:0]   in_cnt_inc;
   logic             in_accept, hit_max, ent_last, ent_ovf;

   assign in_bus.ready = ready_en_reg && (drop_reg || !fifo_full);
   assign in_accept    = in_bus.valid && in_bus.ready;
   assign in_cnt_inc   = {1'b0, in_cnt_reg} + (LEN_W+1)'(1);
   assign hit_max      = (in_cnt_inc == (LEN_W+1)'(MAX_LEN));
   assign ent_last     = in_bus.last || hit_max;
   assign ent_ovf      = hit_max && !in_bus.last;
   assign fifo_push    = in_accept && !drop_reg;
   assign fifo_din     = {ent_ovf, ent_last, in_bus.data};

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ready_en_reg  <= 1'b0;
         drop_reg      <= 1'b0;
         ovf_pulse_reg <= 1'b0;
         in_cnt_reg    <= '0;
      end else begin
         ready_en_reg  <= 1'b1;
         ovf_pulse_reg <= fifo_push && ent_ovf;
         if (fifo_push) begin
            in_cnt_reg <= ent_last ? '0 : in_cnt_inc[LEN_W-1:0];
            if (ent_ovf) begin
               drop_reg <= 1'b1;
            end
         end else if (in_accept && drop_reg && in_bus.last) begin
            drop_reg <= 1'b0;
         end
      end
   end

   pkt_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (fifo_push),
      .din    (fifo_din),
      .pop    (fifo_pop),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // ---------------- output FSM ----------------
   frm_state_t       state_reg, state_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic             ovf_reg, ovf_next;
   logic [SEQ_W-1:0] seq_reg, seq_next;
   logic [DATA_W-1:0] out_data_next;
   logic             out_valid_next, out_last_next;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg <= ST_IDLE;
         len_reg   <= '0;
         ovf_reg   <= 1'b0;
         seq_reg   <= '0;
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         ovf_reg   <= ovf_next;
         seq_reg   <= seq_next;
      end
   end

   // Outputs decode from registered state and the FIFO head register, so they
   // stay frozen while the sink stalls.
   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      ovf_next       = ovf_reg;
      seq_next       = seq_reg;
      fifo_pop       = 1'b0;
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
      out_data_next  = '0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_next = ST_HEADER;
            end
         end
         ST_HEADER: begin
            out_valid_next = 1'b1;
            out_data_next  = HDR_WORD;
            if (out_bus.ready) begin
               state_next = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            out_valid_next = !fifo_empty;
            out_data_next  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
            if (!fifo_empty && out_bus.ready) begin
               fifo_pop = 1'b1;
               len_next = len_reg + LEN_W'(1);
               if (fifo_dout[DATA_W]) begin
                  ovf_next   = fifo_dout[DATA_W+1];
                  state_next = ST_FOOTER;
               end
            end
         end
         ST_FOOTER: begin
            out_valid_next = 1'b1;
            out_last_next  = 1'b1;
            out_data_next  = DATA_W'(make_footer(seq_reg, ovf_reg, len_reg));
            if (out_bus.ready) begin
               seq_next   = seq_reg + SEQ_W'(1);
               len_next   = '0;
               ovf_next   = 1'b0;
               state_next = fifo_empty ? ST_IDLE : ST_HEADER;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign out_bus.data  = out_data_next;
   assign out_bus.valid = out_valid_next;
   assign out_bus.last  = out_last_next;
   assign ovf_pulse     = ovf_pulse_reg;
   assign seq_num       = seq_reg;

endmodule

// File: tb/tb_pkt_framer_bp.sv
// Directed testbench for pkt_framer_bp (DEPTH = 8, MAX_LEN = 8).
module tb_pkt_framer_bp;
   localparam int          DW  = 32;
   localparam logic [31:0] HDR = 32'hFFFF_FFFF;

   logic        clock, resetn;
   logic        ovf_pulse;
   logic [15:0] seq_num;
   int          checks, errors, cyc, ovf_cnt, w;
   logic [32:0] obs_q[$];
   int          obs_cyc_q[$];

   pkt_framer_bp_if #(.DATA_W(DW)) in_bus ();
   pkt_framer_bp_if #(.DATA_W(DW)) out_bus ();

   pkt_framer_bp #(
      .DATA_W   (DW),
      .DEPTH    (8),
      .MAX_LEN  (8),
      .HDR_WORD (HDR)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_bus    (in_bus),
      .out_bus   (out_bus),
      .ovf_pulse (ovf_pulse),
      .seq_num   (seq_num)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Record every accepted output beat as {last, data} with its cycle stamp.
   always @(negedge clock) begin
      if (out_bus.valid && out_bus.ready) begin
         obs_q.push_back({out_bus.last, out_bus.data});
         obs_cyc_q.push_back(cyc);
      end
      if (ovf_pulse) ovf_cnt <= ovf_cnt + 1;
   end

   task automatic send(input logic [31:0] d, input logic l, output int waits);
      in_bus.data  = d;
      in_bus.last  = l;
      in_bus.valid = 1'b1;
      waits = 0;
      @(negedge clock);
      while (in_bus.ready !== 1'b1 && waits < 200) begin
         waits++;
         @(negedge clock);
      end
      if (waits >= 200) begin
         checks++; errors++;
         $display("FAIL send_timeout data=%h in_ready=%b required 1", d, in_bus.ready);
      end
      @(posedge clock); #1;
      in_bus.valid = 1'b0;
      in_bus.last  = 1'b0;
   endtask

   task automatic wait_obs(input int base, input int n, input string name);
      int t = 0;
      while (obs_q.size() < base + n && t < 300) begin
         @(negedge clock);
         t++;
      end
      repeat (4) @(negedge clock);
      #1;
      checks++;
      if (obs_q.size() !== base + n) begin
         errors++;
         $display("FAIL %s_count got %0d required %0d", name, obs_q.size() - base, n);
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      resetn = 1'b0; in_bus.valid = 1'b0; out_bus.ready = 1'b0;
      repeat (2) @(posedge clock);
      #1; resetn = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; in_bus.valid = 1'b0; in_bus.data = '0; in_bus.last = 1'b0;
      out_bus.ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_bus.valid); end
      checks++; if (out_bus.last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b required 0", out_bus.last); end
      checks++; if (out_bus.data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h required 0", out_bus.data); end
      checks++; if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b required 0", in_bus.ready); end
      checks++; if (ovf_pulse !== 1'b0) begin errors++; $display("FAIL rst_ovf_pulse got %b required 0", ovf_pulse); end
      checks++; if (seq_num !== 16'h0) begin errors++; $display("FAIL rst_seq_num got %h required 0", seq_num); end
      resetn = 1'b1;
      @(negedge clock);
      checks++; if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got %b required 0", in_bus.ready); end
      @(negedge clock);
      checks++; if (in_bus.ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b required 1", in_bus.ready); end
      $display("test_reset done");
   endtask

   task automatic test_single();
      logic [32:0] exp [6] = '{{1'b0, HDR}, 33'h0_00000011, 33'h0_00000022,
                               33'h0_00000033, 33'h0_00000044, 33'h1_00000004};
      int base;
      @(posedge clock); #1;
      out_bus.ready = 1'b1;
      base = obs_q.size();
      send(32'h11, 1'b0, w);
      checks++; if (out_bus.valid !== 1'b0) begin errors++; $display("FAIL lat_idle got %b required 0", out_bus.valid); end
      send(32'h22, 1'b0, w);
      checks++; if (out_bus.valid !== 1'b1 || out_bus.data !== HDR) begin errors++; $display("FAIL lat_header got %b/%h required 1/%h", out_bus.valid, out_bus.data, HDR); end
      send(32'h33, 1'b0, w);
      send(32'h44, 1'b1, w);
      wait_obs(base, 6, "single");
      for (int i = 0; i < 6; i++) begin
         logic [32:0] got;
         got = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++;
         if (got !== exp[i]) begin errors++; $display("FAIL single_beat%0d got %h required %h", i, got, exp[i]); end
      end
      checks++; if (seq_num !== 16'd1) begin errors++; $display("FAIL single_seq got %0d required 1", seq_num); end
      $display("test_single done, %0d beats", obs_q.size() - base);
   endtask

   task automatic test_overflow();
      logic [32:0] exp [10] = '{{1'b0, HDR}, 33'h0_00000001, 33'h0_00000002, 33'h0_00000003,
                                33'h0_00000004, 33'h0_00000005, 33'h0_00000006, 33'h0_00000007,
                                33'h0_00000008, 33'h1_00008008};
      int base, ovf0;
      do_reset();
      out_bus.ready = 1'b1;
      base = obs_q.size();
      ovf0 = ovf_cnt;
      for (int i = 1; i <= 12; i++) begin
         send(32'(i), (i == 12), w);
         if (i > 8) begin
            checks++;
            if (w !== 0) begin errors++; $display("FAIL drop_ready word%0d waited %0d required 0", i, w); end
         end
      end
      wait_obs(base, 10, "overflow");
      for (int i = 0; i < 10; i++) begin
         logic [32:0] got;
         got = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++;
         if (got !== exp[i]) begin errors++; $display("FAIL ovf_beat%0d got %h required %h", i, got, exp[i]); end
      end
      checks++; if (ovf_cnt - ovf0 !== 1) begin errors++; $display("FAIL ovf_pulse_cycles got %0d required 1", ovf_cnt - ovf0); end
      $display("test_overflow done, %0d beats", obs_q.size() - base);
   endtask

   task automatic test_stall_toggle();
      logic [32:0] exp [5] = '{{1'b0, HDR}, 33'h0_000000A1, 33'h0_000000A2,
                               33'h0_000000A3, 33'h1_00000003};
      int base;
      logic pv, pr, pl;
      logic [31:0] pd;
      do_reset();
      base = obs_q.size();
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
      fork
         begin
            send(32'hA1, 1'b0, w);
            send(32'hA2, 1'b0, w);
            send(32'hA3, 1'b1, w);
         end
         begin
            repeat (40) begin
               @(negedge clock);
               if (pv && !pr) begin
                  checks++;
                  if (out_bus.valid !== 1'b1 || out_bus.data !== pd || out_bus.last !== pl) begin
                     errors++;
                     $display("FAIL stall_hold got %b/%h/%b required 1/%h/%b", out_bus.valid, out_bus.data, out_bus.last, pd, pl);
                  end
               end
               pv = out_bus.valid; pr = out_bus.ready; pd = out_bus.data; pl = out_bus.last;
               @(posedge clock); #1;
               out_bus.ready = ~out_bus.ready;
            end
         end
      join
      out_bus.ready = 1'b1;
      wait_obs(base, 5, "stall");
      for (int i = 0; i < 5; i++) begin
         logic [32:0] got;
         got = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++;
         if (got !== exp[i]) begin errors++; $display("FAIL stall_beat%0d got %h required %h", i, got, exp[i]); end
      end
      $display("test_stall_toggle done, %0d beats", obs_q.size() - base);
   endtask

   task automatic test_full();
      logic [32:0] exp [14] = '{{1'b0, HDR}, 33'h0_00000051, 33'h0_00000052, 33'h0_00000053,
                                33'h0_00000054, 33'h0_00000055, 33'h1_00000005,
                                {1'b0, HDR}, 33'h0_00000061, 33'h0_00000062, 33'h0_00000063,
                                33'h0_00000064, 33'h0_00000065, 33'h1_00010005};
      logic [31:0] words [8] = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55, 32'h61, 32'h62, 32'h63};
      int base;
      do_reset();
      base = obs_q.size();
      for (int i = 0; i < 8; i++) send(words[i], (i == 4), w);
      in_bus.data = 32'h64; in_bus.last = 1'b0; in_bus.valid = 1'b1;
      @(negedge clock);
      checks++; if (in_bus.ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b required 0", in_bus.ready); end
      checks++; if (out_bus.valid !== 1'b1 || out_bus.data !== HDR) begin errors++; $display("FAIL full_hdr_hold got %b/%h required 1/%h", out_bus.valid, out_bus.data, HDR); end
      @(posedge clock); #1;
      out_bus.ready = 1'b1;
      send(32'h64, 1'b0, w);
      send(32'h65, 1'b1, w);
      wait_obs(base, 14, "full");
      for (int i = 0; i < 14; i++) begin
         logic [32:0] got;
         got = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++;
         if (got !== exp[i]) begin errors++; $display("FAIL full_beat%0d got %h required %h", i, got, exp[i]); end
      end
      $display("test_full done, %0d beats", obs_q.size() - base);
   endtask

   task automatic test_back_to_back();
      logic [32:0] exp [7] = '{{1'b0, HDR}, 33'h0_00000071, 33'h1_00000001,
                               {1'b0, HDR}, 33'h0_00000081, 33'h0_00000082, 33'h1_00010002};
      int base, gap;
      do_reset();
      out_bus.ready = 1'b1;
      base = obs_q.size();
      send(32'h71, 1'b1, w);
      send(32'h81, 1'b0, w);
      send(32'h82, 1'b1, w);
      wait_obs(base, 7, "b2b");
      for (int i = 0; i < 7; i++) begin
         logic [32:0] got;
         got = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++;
         if (got !== exp[i]) begin errors++; $display("FAIL b2b_beat%0d got %h required %h", i, got, exp[i]); end
      end
      gap = (obs_cyc_q.size() > base + 3) ? obs_cyc_q[base + 3] - obs_cyc_q[base + 2] : -1;
      checks++; if (gap !== 1) begin errors++; $display("FAIL b2b_gap got %0d required 1", gap); end
      $display("test_back_to_back done, %0d beats", obs_q.size() - base);
   endtask

   task automatic test_reset_mid();
      logic [32:0] exp [3] = '{{1'b0, HDR}, 33'h0_000000B1, 33'h1_00000001};
      int base;
      out_bus.ready = 1'b1;
      send(32'h91, 1'b0, w);
      send(32'h92, 1'b0, w);
      send(32'h93, 1'b0, w);
      send(32'h94, 1'b0, w);
      checks++; if (out_bus.valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b required 1", out_bus.valid); end
      resetn = 1'b0;
      #2;
      checks++; if (out_bus.valid !== 1'b0 || out_bus.last !== 1'b0) begin errors++; $display("FAIL mid_rst_vl got %b/%b required 0/0", out_bus.valid, out_bus.last); end
      checks++; if (out_bus.data !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h required 0", out_bus.data); end
      checks++; if (in_bus.ready !== 1'b0 || ovf_pulse !== 1'b0) begin errors++; $display("FAIL mid_rst_ready_ovf got %b/%b required 0/0", in_bus.ready, ovf_pulse); end
      checks++; if (seq_num !== 16'h0) begin errors++; $display("FAIL mid_rst_seq got %h required 0", seq_num); end
      @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;
      base = obs_q.size();
      send(32'hB1, 1'b1, w);
      wait_obs(base, 3, "mid");
      for (int i = 0; i < 3; i++) begin
         logic [32:0] got;
         got = (base + i < obs_q.size()) ? obs_q[base + i] : 'x;
         checks++;
         if (got !== exp[i]) begin errors++; $display("FAIL mid_beat%0d got %h required %h", i, got, exp[i]); end
      end
      $display("test_reset_mid done, %0d beats", obs_q.size() - base);
   endtask

   initial begin
      checks = 0; errors = 0; w = 0;
      test_reset();
      test_single();
      test_overflow();
      test_stall_toggle();
      test_full();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
